// File: rtl/dmem_store_responder.sv
// Purpose : word-addressed data RAM for the core's load/store port, plus a sticky PASS/FAIL completion monitor.
// Latency : ReadData is combinational (0 cycles); RAM write, counters and Done/Pass update on the next clk edge.
// Backpressure: none; every store is accepted or judged in the cycle it is presented, nothing is ever stalled.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-low reset
//   MemWrite        store strobe from the core
//   DataAdr         byte address (loads and stores)
//   WriteData       store data
//   ReadData        load data; 0 for misaligned or out-of-range addresses
//   Done / Pass     program finished (sticky) / finished successfully
//   StoreCount      accepted stores, saturating
//   CycleCount      clock edges spent in RUN
//   FailAdr         address of the store that caused FAIL, all-ones on timeout
module dmem_store_responder #(
    parameter int MEM_WORDS    = 64,
    parameter int DONE_ADDR    = 100,
    parameter int DONE_VALUE   = 25,
    parameter int SCRATCH_ADDR = 96,
    parameter int STRICT       = 1,
    parameter int TIMEOUT      = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Done,
    output logic        Pass,
    output logic [15:0] StoreCount,
    output logic [31:0] CycleCount,
    output logic [31:0] FailAdr
);

    localparam int          AW          = $clog2(MEM_WORDS);
    localparam logic [31:0] BYTE_LIMIT  = 32'(4 * MEM_WORDS);
    localparam logic [31:0] DONE_A      = 32'(DONE_ADDR);
    localparam logic [31:0] DONE_V      = 32'(DONE_VALUE);
    localparam logic [31:0] SCRATCH_A   = 32'(SCRATCH_ADDR);
    localparam logic [31:0] TIMEOUT_M1  = 32'(TIMEOUT - 1);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_PASS = 2'd1;
    localparam logic [1:0] ST_FAIL = 2'd2;

    logic [31:0] mem [MEM_WORDS];

    logic [1:0]  state_q,     state_d;
    logic [15:0] store_cnt_q, store_cnt_d;
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] fail_adr_q,  fail_adr_d;

    logic [AW-1:0] word_idx;
    logic          addr_ok;
    logic          addr_allowed;
    logic          store_legal;
    logic          is_done_store;
    logic          timeout_hit;
    logic          mem_we;
    logic          cnt_inc;

    assign word_idx = DataAdr[AW+1:2];
    assign addr_ok  = (DataAdr[1:0] == 2'b00) && (DataAdr < BYTE_LIMIT);

    // Read port ignores MemWrite; a same-cycle store lands at the edge, so the old word is returned.
    assign ReadData = addr_ok ? mem[word_idx] : 32'h0;

    // In strict mode only the scratch and done words may be stored to.
    assign addr_allowed  = (STRICT == 0) || (DataAdr == SCRATCH_A) || (DataAdr == DONE_A);
    assign store_legal   = MemWrite && addr_ok && addr_allowed;
    assign is_done_store = MemWrite && (DataAdr == DONE_A);
    assign timeout_hit   = (TIMEOUT != 0) && (cycle_cnt_q == TIMEOUT_M1);

    always_comb begin
        state_d     = state_q;
        store_cnt_d = store_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        fail_adr_d  = fail_adr_q;
        mem_we      = 1'b0;
        cnt_inc     = 1'b0;

        if (state_q == ST_RUN) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
            // A store that decides the outcome takes priority over the timeout.
            if (is_done_store) begin
                if (WriteData == DONE_V) begin
                    state_d = ST_PASS;
                    // The done word may sit outside the RAM; it still counts but is not written.
                    mem_we  = addr_ok;
                    cnt_inc = 1'b1;
                end else begin
                    state_d    = ST_FAIL;
                    fail_adr_d = DataAdr;
                end
            end else if (MemWrite && !store_legal) begin
                state_d    = ST_FAIL;
                fail_adr_d = DataAdr;
            end else begin
                if (store_legal) begin
                    mem_we  = 1'b1;
                    cnt_inc = 1'b1;
                end
                if (timeout_hit) begin
                    state_d    = ST_FAIL;
                    fail_adr_d = 32'hFFFF_FFFF;
                end
            end
        end

        if (cnt_inc && (store_cnt_q != 16'hFFFF)) begin
            store_cnt_d = store_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            store_cnt_q <= 16'h0;
            cycle_cnt_q <= 32'h0;
            fail_adr_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            store_cnt_q <= store_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            fail_adr_q  <= fail_adr_d;
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_idx] <= WriteData;
        end
    end

    assign Done       = (state_q == ST_PASS) || (state_q == ST_FAIL);
    assign Pass       = (state_q == ST_PASS);
    assign StoreCount = store_cnt_q;
    assign CycleCount = cycle_cnt_q;
    assign FailAdr    = fail_adr_q;

endmodule

// File: tb/tb_dmem_store_responder.sv
// Purpose : random and directed stimulus for two responder instances (strict/long timeout, relaxed/short timeout).
// Latency : outputs compared every negedge against a behavioural model stepped at each posedge.
// Backpressure: not applicable; stimulus is applied one store per cycle.
module tb_dmem_store_responder;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        MemWrite  = 1'b0;
    logic [31:0] DataAdr   = 32'h0;
    logic [31:0] WriteData = 32'h0;

    logic [31:0] rd   [2];
    logic        done [2];
    logic        pass [2];
    logic [15:0] scnt [2];
    logic [31:0] ccnt [2];
    logic [31:0] fadr [2];

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    always #5 clk = ~clk;

    dmem_store_responder #(.MEM_WORDS(64), .DONE_ADDR(100), .DONE_VALUE(25), .SCRATCH_ADDR(96),
                           .STRICT(1), .TIMEOUT(64)) dut0 (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .ReadData(rd[0]), .Done(done[0]), .Pass(pass[0]), .StoreCount(scnt[0]),
        .CycleCount(ccnt[0]), .FailAdr(fadr[0]));

    dmem_store_responder #(.MEM_WORDS(64), .DONE_ADDR(100), .DONE_VALUE(25), .SCRATCH_ADDR(96),
                           .STRICT(0), .TIMEOUT(16)) dut1 (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .ReadData(rd[1]), .Done(done[1]), .Pass(pass[1]), .StoreCount(scnt[1]),
        .CycleCount(ccnt[1]), .FailAdr(fadr[1]));

    // ---------------- behavioural model ----------------
    // status: 0 running, 1 passed, 2 failed
    int          m_st  [2];
    logic [15:0] m_sc  [2];
    logic [31:0] m_cc  [2];
    logic [31:0] m_fa  [2];
    logic [31:0] m_mem [2][64];
    bit          m_known [2][64];

    function automatic bit p_strict(int i);
        return (i == 0);
    endfunction

    function automatic int p_tmo(int i);
        return (i == 0) ? 64 : 16;
    endfunction

    function automatic bit in_ram(logic [31:0] a);
        return (a % 4 == 0) && (a < 256);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0;
            m_sc[i] = 16'h0;
            m_cc[i] = 32'h0;
            m_fa[i] = 32'h0;
        end
    endtask

    task automatic model_store(int i, logic [31:0] a, logic [31:0] d);
        if (in_ram(a)) begin
            m_mem[i][a / 4]   = d;
            m_known[i][a / 4] = 1'b1;
        end
        if (m_sc[i] != 16'hFFFF) m_sc[i] = m_sc[i] + 16'd1;
    endtask

    task automatic model_step(int i, bit we, logic [31:0] a, logic [31:0] d);
        logic [31:0] edges_before;
        bit          legal;
        if (m_st[i] != 0) return;
        edges_before = m_cc[i];
        m_cc[i] = m_cc[i] + 1;
        legal = we && in_ram(a) && (!p_strict(i) || a == 96 || a == 100);
        if (we && a == 100) begin
            if (d == 25) begin
                model_store(i, a, d);
                m_st[i] = 1;
            end else begin
                m_st[i] = 2;
                m_fa[i] = a;
            end
            return;
        end
        if (we && !legal) begin
            m_st[i] = 2;
            m_fa[i] = a;
            return;
        end
        if (legal) model_store(i, a, d);
        if (p_tmo(i) != 0 && edges_before == 32'(p_tmo(i) - 1)) begin
            m_st[i] = 2;
            m_fa[i] = 32'hFFFF_FFFF;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("done%0d", i), 32'(done[i]), 32'(m_st[i] != 0));
                chk($sformatf("pass%0d", i), 32'(pass[i]), 32'(m_st[i] == 1));
                chk($sformatf("storecount%0d", i), 32'(scnt[i]), 32'(m_sc[i]));
                chk($sformatf("cyclecount%0d", i), ccnt[i], m_cc[i]);
                chk($sformatf("failadr%0d", i), fadr[i], m_fa[i]);
                if (!in_ram(DataAdr)) begin
                    chk($sformatf("readdata_oor%0d", i), rd[i], 32'h0);
                end else if (m_known[i][DataAdr / 4]) begin
                    chk($sformatf("readdata%0d", i), rd[i], m_mem[i][DataAdr / 4]);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Waits one edge and steps the model with the inputs that were present at that edge.
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) model_step(i, MemWrite, DataAdr, WriteData);
        end
        #1;
    endtask

    task automatic apply(bit we, logic [31:0] a, logic [31:0] d);
        MemWrite  = we;
        DataAdr   = a;
        WriteData = d;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic look(logic [31:0] a);
        DataAdr = a;
        #1;
    endtask

    logic [31:0] ra;
    logic [31:0] rdat;

    initial begin
        do_reset();
        chk_en = 1'b1;

        // 1: scratch store then passing done store
        apply(1'b1, 32'd96, 32'd7);
        apply(1'b1, 32'd100, 32'd25);
        look(32'd100);
        chk("t1_done", 32'(done[0]), 32'd1);
        chk("t1_pass", 32'(pass[0]), 32'd1);
        chk("t1_count", 32'(scnt[0]), 32'd2);
        chk("t1_ram25", rd[0], 32'd25);
        chk("t1_failadr", fadr[0], 32'd0);
        chk("t1_model_count", 32'(m_sc[0]), 32'd2);

        // 2: wrong done value
        do_reset();
        apply(1'b1, 32'd100, 32'd24);
        chk("t2_done", 32'(done[0]), 32'd1);
        chk("t2_pass", 32'(pass[0]), 32'd0);
        chk("t2_failadr", fadr[0], 32'd100);
        chk("t2_count", 32'(scnt[0]), 32'd0);

        // 3: store to a non-scratch word, strict vs relaxed
        do_reset();
        apply(1'b1, 32'd52, 32'd5);
        look(32'd52);
        chk("t3_strict_done", 32'(done[0]), 32'd1);
        chk("t3_strict_failadr", fadr[0], 32'd52);
        chk("t3_relaxed_done", 32'(done[1]), 32'd0);
        chk("t3_relaxed_ram13", rd[1], 32'd5);

        // 4: misaligned, then out of range
        do_reset();
        apply(1'b1, 32'd98, 32'd1);
        chk("t4_mis_failadr0", fadr[0], 32'd98);
        chk("t4_mis_failadr1", fadr[1], 32'd98);
        do_reset();
        apply(1'b1, 32'd256, 32'd1);
        look(32'd256);
        chk("t4_oor_failadr", fadr[1], 32'd256);
        chk("t4_oor_read", rd[1], 32'd0);

        // 5: timeout on the relaxed instance (16 cycles)
        do_reset();
        for (int k = 0; k < 15; k++) tick();
        chk("t5_not_yet", 32'(done[1]), 32'd0);
        tick();
        chk("t5_done", 32'(done[1]), 32'd1);
        chk("t5_pass", 32'(pass[1]), 32'd0);
        chk("t5_failadr", fadr[1], 32'hFFFF_FFFF);
        chk("t5_cycles", ccnt[1], 32'd16);
        for (int k = 0; k < 5; k++) tick();
        chk("t5_cycles_frozen", ccnt[1], 32'd16);
        chk("t5_model_cycles", m_cc[1], 32'd16);

        // 6: stores after PASS are ignored; short reset keeps RAM
        do_reset();
        apply(1'b1, 32'd96, 32'd9);
        apply(1'b1, 32'd100, 32'd25);
        apply(1'b1, 32'd96, 32'd1);
        look(32'd96);
        chk("t6_count_frozen", 32'(scnt[0]), 32'd2);
        chk("t6_ram24_kept", rd[0], 32'd9);
        reset = 1'b0;
        model_reset();
        #1;
        chk("t6_reset_done", 32'(done[0]), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_ram24_after_reset", rd[0], 32'd9);

        // random runs
        for (int run = 0; run < 250; run++) begin
            do_reset();
            for (int c = 0; c < int'($urandom_range(5, 80)); c++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: ra = 32'd96;
                    4:          ra = 32'd100;
                    5:          ra = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                    6:          ra = 32'd52;
                    7:          ra = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
                    8:          ra = 32'd256 + $urandom_range(0, 1023);
                    default:    ra = $urandom;
                endcase
                if (ra == 32'd100 && $urandom_range(0, 1) == 0) rdat = 32'd25;
                else if (ra == 32'd100) rdat = $urandom_range(0, 50);
                else rdat = $urandom;
                apply($urandom_range(0, 99) < 40, ra, rdat);
                if ($urandom_range(0, 59) == 0) begin
                    reset = 1'b0;
                    model_reset();
                    #3;
                    reset = 1'b1;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
